lab61soc_sw_ctrl: RTL and testbench

LAB61SOC_SW_CTRL -- requirements
Module: lab61soc_sw_ctrl

---
 rtl/lab61soc_sw_pkg.sv | 25 ++
 rtl/lab61soc_sw_ctrl_if.sv | 27 ++
 rtl/lab61soc_sw_debounce.sv | 57 +++++
 rtl/lab61soc_sw_ctrl.sv | 89 ++++++++
 tb/tb_lab61soc_sw_ctrl.sv | 215 +++++++++++++++++++++
 5 files changed

// File: rtl/lab61soc_sw_pkg.sv
// Shared constants and helpers for the lab61soc switch controller.
package lab61soc_sw_pkg;

    localparam logic [1:0] ADDR_DATA   = 2'd0;
    localparam logic [1:0] ADDR_MASK   = 2'd1;
    localparam logic [1:0] ADDR_EDGE   = 2'd2;
    localparam logic [1:0] ADDR_STATUS = 2'd3;

    localparam int DEBOUNCE_CYCLES_DEFAULT = 50000;
    localparam int AVL_DATA_W              = 32;

    // Bits needed to hold 0..value-1; never less than one bit.
    function automatic int clog2(input int value);
        int r;
        int v;
        r = 0;
        v = value - 1;
        while (v > 0) begin
            r = r + 1;
            v = v >> 1;
        end
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/lab61soc_sw_ctrl_if.sv
// Avalon-MM slave register bus of the switch controller.
interface lab61soc_sw_ctrl_if;
    import lab61soc_sw_pkg::*;

    logic [1:0]            address;
    logic                  chipselect;
    logic                  write_n;
    logic [AVL_DATA_W-1:0] writedata;
    logic [AVL_DATA_W-1:0] readdata;

    modport master (
        output address,
        output chipselect,
        output write_n,
        output writedata,
        input  readdata
    );

    modport slave (
        input  address,
        input  chipselect,
        input  write_n,
        input  writedata,
        output readdata
    );

endinterface

// File: rtl/lab61soc_sw_debounce.sv
// One switch bit: 2-flop synchronizer followed by a stability counter.
// chg is high in the cycle whose closing edge flips deb.
module lab61soc_sw_debounce
    import lab61soc_sw_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
    input  logic clk,
    input  logic reset_n,
    input  logic din,
    output logic deb,
    output logic chg
);

    localparam int                CNT_W   = clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync_p0;
    logic             sync_p1;
    logic [CNT_W-1:0] cnt_p1;

    // Counter increment that holds at its terminal count instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == CNT_MAX) ? v : v + 1'b1;
    endfunction

    assign chg = (sync_p1 != deb) && (cnt_p1 == CNT_MAX);

    // Stage p0/p1: bring the asynchronous switch level into the clk domain.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            sync_p0 <= 1'b0;
            sync_p1 <= 1'b0;
        end else begin
            sync_p0 <= din;
            sync_p1 <= sync_p0;
        end
    end

    // Count consecutive mismatch cycles; any return to deb discards the change.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            cnt_p1 <= '0;
            deb    <= 1'b0;
        end else begin
            if ((sync_p1 == deb) || chg) begin
                cnt_p1 <= '0;
            end else begin
                cnt_p1 <= sat_inc(cnt_p1);
            end
            if (chg) begin
                deb <= sync_p1;
            end
        end
    end

endmodule

// File: rtl/lab61soc_sw_ctrl.sv
// Debounced switch input port with edge capture, interrupt mask and
// Avalon-MM register access.
module lab61soc_sw_ctrl
    import lab61soc_sw_pkg::*;
#(
    parameter int WIDTH           = 8,
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
    input  logic               clk,
    input  logic               reset_n,
    lab61soc_sw_ctrl_if.slave  bus,
    input  logic [WIDTH-1:0]   in_port,
    output logic               irq
);

    logic [WIDTH-1:0]      deb;
    logic [WIDTH-1:0]      chg;
    logic [WIDTH-1:0]      mask_q;
    logic [WIDTH-1:0]      edge_q;
    logic [WIDTH-1:0]      edge_clr;
    logic [AVL_DATA_W-1:0] rd_next;
    logic                  wr_en;
    logic                  unused_wdata;

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        lab61soc_sw_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_debounce (
            .clk    (clk),
            .reset_n(reset_n),
            .din    (in_port[i]),
            .deb    (deb[i]),
            .chg    (chg[i])
        );
    end

    assign wr_en        = bus.chipselect && !bus.write_n;
    assign edge_clr     = (wr_en && (bus.address == ADDR_EDGE)) ? bus.writedata[WIDTH-1:0] : '0;
    assign unused_wdata = &{1'b0, bus.writedata};

    // MASK register; writes to DATA and STATUS fall through untouched.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            mask_q <= '0;
        end else if (wr_en && (bus.address == ADDR_MASK)) begin
            mask_q <= bus.writedata[WIDTH-1:0];
        end
    end

    // Sticky edge flags; a new debounced change beats a same-cycle clear.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            edge_q <= '0;
        end else begin
            edge_q <= (edge_q & ~edge_clr) | chg;
        end
    end

    // Interrupt is the registered OR of unmasked edge flags.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            irq <= 1'b0;
        end else begin
            irq <= |(edge_q & mask_q);
        end
    end

    // Address-selected register value, zero-extended to the bus width.
    always_comb begin
        rd_next = '0;
        case (bus.address)
            ADDR_DATA:   rd_next[WIDTH-1:0] = deb;
            ADDR_MASK:   rd_next[WIDTH-1:0] = mask_q;
            ADDR_EDGE:   rd_next[WIDTH-1:0] = edge_q;
            ADDR_STATUS: rd_next[0]         = irq;
            default:     rd_next            = '0;
        endcase
    end

    // Read data refreshes every cycle regardless of chipselect.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            bus.readdata <= '0;
        end else begin
            bus.readdata <= rd_next;
        end
    end

endmodule

// File: tb/tb_lab61soc_sw_ctrl.sv
// Directed scoreboard bench for lab61soc_sw_ctrl (WIDTH=8, DEBOUNCE_CYCLES=4).
module tb_lab61soc_sw_ctrl;

    localparam int K_RD  = 0;
    localparam int K_IRQ = 1;

    typedef struct {
        int          kind;
        logic [31:0] exp;
        string       tag;
    } exp_t;

    logic       clk;
    logic       reset_n;
    logic [7:0] in_port;
    logic       irq;
    int         checks;
    int         errors;
    exp_t       sbq[$];

    lab61soc_sw_ctrl_if bus ();

    lab61soc_sw_ctrl #(
        .WIDTH          (8),
        .DEBOUNCE_CYCLES(4)
    ) dut (
        .clk    (clk),
        .reset_n(reset_n),
        .bus    (bus),
        .in_port(in_port),
        .irq    (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic push(input int kind, input logic [31:0] exp, input string tag);
        exp_t e;
        e.kind = kind;
        e.exp  = exp;
        e.tag  = tag;
        sbq.push_back(e);
    endtask

    // Advance one edge, then retire every expectation queued for it.
    task automatic step();
        exp_t        e;
        logic [31:0] obs;
        @(posedge clk);
        #1;
        while (sbq.size() > 0) begin
            e   = sbq.pop_front();
            obs = (e.kind == K_IRQ) ? {31'd0, irq} : bus.readdata;
            checks++;
            assert (obs === e.exp)
            else begin
                errors++;
                $error("FAIL %s observed=%h expected=%h", e.tag, obs, e.exp);
            end
        end
    endtask

    task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
        bus.chipselect = 1'b1;
        bus.write_n    = 1'b0;
        bus.address    = a;
        bus.writedata  = d;
        step();
        bus.chipselect = 1'b0;
        bus.write_n    = 1'b1;
        bus.writedata  = '0;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        in_port = 8'h00;
        step();
        step();
        reset_n = 1'b1;
    endtask

    initial begin
        checks         = 0;
        errors         = 0;
        reset_n        = 1'b0;
        in_port        = 8'h00;
        bus.address    = 2'd0;
        bus.chipselect = 1'b0;
        bus.write_n    = 1'b1;
        bus.writedata  = '0;

        // Reset state
        step();
        push(K_RD, 32'h0, "rst_rd");
        push(K_IRQ, 32'h0, "rst_irq");
        step();

        // Debounce accept: 0x05 applied before edge 0, deb flips at edge 5
        reset_n = 1'b1;
        in_port = 8'h05;
        for (int i = 0; i < 6; i++) begin
            push(K_RD, 32'h0, "acc_early");
            step();
        end
        push(K_RD, 32'h05, "acc_data");
        push(K_IRQ, 32'h0, "acc_irq");
        step();
        bus.address = 2'd2;
        push(K_RD, 32'h05, "acc_edge");
        step();
        bus.address = 2'd3;
        push(K_RD, 32'h0, "acc_status");
        step();
        bus_write(2'd0, 32'h0);
        bus.address = 2'd0;
        push(K_RD, 32'h05, "ro_data");
        step();

        // Bounce reject: bit0 high for only 3 cycles
        do_reset();
        in_port = 8'h01;
        step();
        step();
        step();
        in_port = 8'h00;
        for (int i = 0; i < 8; i++) begin
            push(K_IRQ, 32'h0, "bnc_irq");
            step();
        end
        bus.address = 2'd0;
        push(K_RD, 32'h0, "bnc_data");
        step();
        bus.address = 2'd2;
        push(K_RD, 32'h0, "bnc_edge");
        step();

        // Interrupt flow: mask bit0, raise bit0, clear via EDGE
        do_reset();
        bus_write(2'd1, 32'h01);
        bus.address = 2'd1;
        push(K_RD, 32'h01, "msk_rd");
        step();
        in_port = 8'h01;
        for (int i = 0; i < 7; i++) begin
            push(K_IRQ, (i == 6) ? 32'h1 : 32'h0, "irq_assert");
            step();
        end
        bus.address = 2'd3;
        push(K_RD, 32'h1, "irq_status");
        step();
        push(K_IRQ, 32'h1, "irq_hold");
        bus_write(2'd2, 32'h01);
        bus.address = 2'd2;
        push(K_IRQ, 32'h0, "irq_clr");
        push(K_RD, 32'h0, "edge_clr");
        step();

        // Set wins: clear bit1 on the very edge its deb rises
        in_port = 8'h03;
        for (int i = 0; i < 5; i++) begin
            step();
        end
        bus_write(2'd2, 32'h02);
        bus.address = 2'd2;
        push(K_RD, 32'h02, "set_wins");
        push(K_IRQ, 32'h0, "set_wins_irq");
        step();

        // Falling change also captured
        bus_write(2'd2, 32'h02);
        bus.address = 2'd2;
        push(K_RD, 32'h0, "edge_w1c2");
        step();
        in_port = 8'h01;
        for (int i = 0; i < 6; i++) begin
            push(K_RD, 32'h0, "fall_early");
            step();
        end
        push(K_RD, 32'h02, "fall_edge");
        step();
        bus.address = 2'd0;
        push(K_RD, 32'h01, "fall_data");
        step();

        // Reset mid-debounce at counter=2, then full latency after release
        do_reset();
        bus_write(2'd1, 32'hFF);
        in_port     = 8'h08;
        bus.address = 2'd0;
        for (int i = 0; i < 4; i++) begin
            step();
        end
        reset_n = 1'b0;
        push(K_RD, 32'h0, "mid_rst_rd");
        push(K_IRQ, 32'h0, "mid_rst_irq");
        step();
        reset_n = 1'b1;
        for (int i = 0; i < 7; i++) begin
            push(K_RD, (i == 6) ? 32'h08 : 32'h0, "mid_data");
            push(K_IRQ, 32'h0, "mid_irq");
            step();
        end
        bus.address = 2'd1;
        push(K_RD, 32'h0, "mid_mask");
        step();
        bus.address = 2'd2;
        push(K_RD, 32'h08, "mid_edge");
        push(K_IRQ, 32'h0, "mid_irq_end");
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
